bank_cmd_arbiter: RTL

BANK_CMD_ARBITER -- requirements
Module: bank_cmd_arbiter

---
 rtl/bank_cmd_arbiter_pkg.sv | 54 +++++
 rtl/timing_down_counter.sv | 40 ++++
 rtl/bank_cmd_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bank_cmd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bank_cmd_arbiter_pkg
// Shared definitions for the bank command arbiter:
//   - FSM state encoding (ARB / REF_WAIT / REF_ISSUE / REF_HOLD)
//   - command class codes (ACT, PRE, RD, WR, plus "none of the above")
//   - 8-bit timing configuration type
//   - per-request command class decode helper
// No ports (package).
// ---------------------------------------------------------------------------
package bank_cmd_arbiter_pkg;

    localparam int BANK_IDX_W = 2;
    localparam int ADDR_W     = 17;
    localparam int BA_W       = 3;

    typedef logic [7:0] timing_cfg_t;

    localparam logic [1:0] ST_ARB       = 2'd0;
    localparam logic [1:0] ST_REF_WAIT  = 2'd1;
    localparam logic [1:0] ST_REF_ISSUE = 2'd2;
    localparam logic [1:0] ST_REF_HOLD  = 2'd3;

    localparam logic [2:0] CLS_NONE = 3'd0;
    localparam logic [2:0] CLS_ACT  = 3'd1;
    localparam logic [2:0] CLS_PRE  = 3'd2;
    localparam logic [2:0] CLS_RD   = 3'd3;
    localparam logic [2:0] CLS_WR   = 3'd4;

    // Row commands need ~cas; column commands need cas. A request that is both
    // read and write is treated as a read.
    function automatic logic [2:0] decode_cmd_class(
        input logic is_cmd,
        input logic ras,
        input logic cas,
        input logic we,
        input logic is_read,
        input logic is_write
    );
        logic [2:0] cls;
        if (is_cmd && ras && !cas && !we) begin
            cls = CLS_ACT;
        end else if (is_cmd && ras && !cas && we) begin
            cls = CLS_PRE;
        end else if (cas && is_read) begin
            cls = CLS_RD;
        end else if (cas && is_write) begin
            cls = CLS_WR;
        end else begin
            cls = CLS_NONE;
        end
        return cls;
    endfunction

endpackage

// File: rtl/timing_down_counter.sv
// ---------------------------------------------------------------------------
// timing_down_counter
// Minimum-spacing timer. A load arms it with cfg-1 (0 when cfg is 0); it then
// counts down to 0 and stops. ok is high while the count is 0, so a command
// constrained by cfg=N may issue N cycles after the loading command.
// Ports:
//   sys_clk    in   clock
//   sys_rst_n  in   asynchronous active-low reset (count -> 0)
//   load       in   triggering command issued this cycle
//   cfg        in   8-bit spacing in cycles
//   ok         out  count == 0
// ---------------------------------------------------------------------------
module timing_down_counter
    import bank_cmd_arbiter_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       load,
    input  logic [7:0] cfg,
    output logic       ok
);

    timing_cfg_t count_r;

    // Load on trigger, otherwise count down without wrapping below zero.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= (cfg == 8'd0) ? 8'd0 : (cfg - 8'd1);
        end else if (count_r != 8'd0) begin
            count_r <= count_r - 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign ok = (count_r == 8'd0);

endmodule

// File: rtl/bank_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// bank_cmd_arbiter
// Round-robin arbiter that picks one bank-machine command per cycle, subject
// to ACT->ACT, col->col, WR->RD and RD->WR spacing, and inserts a REF command
// once every bank has yielded to a refresh request.
// Ports:
//   sys_clk, sys_rst_n        clock, async active-low reset
//   bm_cmd_valid/ready        per-bank request / combinational one-hot grant
//   bm_cmd_a, bm_cmd_ba       per-bank packed address / bank address
//   bm_cmd_cas..is_write      per-bank command flags
//   bm_refresh_gnt            per-bank "row closed, ready for refresh"
//   refresh_req/refresh_done  refresh handshake (done pulses on REF issue)
//   cfg_tRRD/tCCD/tWTR/tRTW   8-bit spacing configuration
//   phy_cmd_*                 registered command to the PHY (latency 1)
// ---------------------------------------------------------------------------
module bank_cmd_arbiter
    import bank_cmd_arbiter_pkg::*;
#(
    parameter int NBANK = 4
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NBANK-1:0]        bm_cmd_valid,
    output logic [NBANK-1:0]        bm_cmd_ready,
    input  logic [ADDR_W*NBANK-1:0] bm_cmd_a,
    input  logic [BA_W*NBANK-1:0]   bm_cmd_ba,
    input  logic [NBANK-1:0]        bm_cmd_cas,
    input  logic [NBANK-1:0]        bm_cmd_ras,
    input  logic [NBANK-1:0]        bm_cmd_we,
    input  logic [NBANK-1:0]        bm_cmd_is_cmd,
    input  logic [NBANK-1:0]        bm_cmd_is_read,
    input  logic [NBANK-1:0]        bm_cmd_is_write,
    input  logic [NBANK-1:0]        bm_refresh_gnt,
    input  logic                    refresh_req,
    output logic                    refresh_done,
    input  logic [7:0]              cfg_tRRD,
    input  logic [7:0]              cfg_tCCD,
    input  logic [7:0]              cfg_tWTR,
    input  logic [7:0]              cfg_tRTW,
    output logic                    phy_cmd_valid,
    output logic [16:0]             phy_cmd_a,
    output logic [2:0]              phy_cmd_ba,
    output logic                    phy_cmd_cas,
    output logic                    phy_cmd_ras,
    output logic                    phy_cmd_we,
    output logic                    phy_cmd_is_read,
    output logic                    phy_cmd_is_write
);

    logic [1:0]                  state_r;
    logic [1:0]                  state_nxt_s;
    logic [BANK_IDX_W-1:0]       rr_ptr_r;
    logic [BANK_IDX_W-1:0]       grant_idx_s;
    logic [BANK_IDX_W-1:0]       cand_s;
    logic                        grant_s;
    logic                        init_done_r;
    logic                        arb_en_s;
    logic [NBANK-1:0][2:0]       cls_s;
    logic [NBANK-1:0]            elig_s;
    logic [2:0]                  grant_cls_s;
    logic                        trrd_ok_s;
    logic                        tccd_ok_s;
    logic                        twtr_ok_s;
    logic                        trtw_ok_s;
    logic                        load_trrd_s;
    logic                        load_tccd_s;
    logic                        load_twtr_s;
    logic                        load_trtw_s;

    // Grants are held off in the first cycle after reset release so nothing
    // is issued off a partially-released reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            init_done_r <= 1'b0;
        end else begin
            init_done_r <= 1'b1;
        end
    end

    assign arb_en_s = (state_r == ST_ARB) && init_done_r;

    // Classify each request and check it against the spacing timers.
    always_comb begin
        cls_s  = {NBANK{3'd0}};
        elig_s = {NBANK{1'b0}};
        for (int i = 0; i < NBANK; i++) begin
            cls_s[i] = decode_cmd_class(bm_cmd_is_cmd[i], bm_cmd_ras[i], bm_cmd_cas[i],
                                        bm_cmd_we[i], bm_cmd_is_read[i], bm_cmd_is_write[i]);
            case (cls_s[i])
                CLS_ACT: elig_s[i] = trrd_ok_s;
                CLS_PRE: elig_s[i] = 1'b1;
                CLS_RD:  elig_s[i] = tccd_ok_s & twtr_ok_s;
                CLS_WR:  elig_s[i] = tccd_ok_s & trtw_ok_s;
                default: elig_s[i] = 1'b1;
            endcase
        end
    end

    // Round-robin search upward from rr_ptr; the 2-bit index wraps modulo 4.
    always_comb begin
        grant_s     = 1'b0;
        grant_idx_s = {BANK_IDX_W{1'b0}};
        cand_s      = {BANK_IDX_W{1'b0}};
        for (int off = 0; off < NBANK; off++) begin
            cand_s = rr_ptr_r + BANK_IDX_W'(off);
            if (arb_en_s && !grant_s && bm_cmd_valid[cand_s] && elig_s[cand_s]) begin
                grant_s     = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_s     = grant_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // One-hot grant back to the winning bank machine.
    always_comb begin
        bm_cmd_ready = {NBANK{1'b0}};
        for (int i = 0; i < NBANK; i++) begin
            bm_cmd_ready[i] = grant_s && (grant_idx_s == BANK_IDX_W'(i));
        end
    end

    assign grant_cls_s = cls_s[grant_idx_s];
    assign load_trrd_s = grant_s && (grant_cls_s == CLS_ACT);
    assign load_tccd_s = grant_s && ((grant_cls_s == CLS_RD) || (grant_cls_s == CLS_WR));
    assign load_twtr_s = grant_s && (grant_cls_s == CLS_WR);
    assign load_trtw_s = grant_s && (grant_cls_s == CLS_RD);

    timing_down_counter u_trrd (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (load_trrd_s),
        .cfg       (cfg_tRRD),
        .ok        (trrd_ok_s)
    );

    timing_down_counter u_tccd (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (load_tccd_s),
        .cfg       (cfg_tCCD),
        .ok        (tccd_ok_s)
    );

    timing_down_counter u_twtr (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (load_twtr_s),
        .cfg       (cfg_tWTR),
        .ok        (twtr_ok_s)
    );

    timing_down_counter u_trtw (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (load_trtw_s),
        .cfg       (cfg_tRTW),
        .ok        (trtw_ok_s)
    );

    // Refresh sequencing; a grant in the cycle refresh_req is seen still issues.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ARB: begin
                if (refresh_req) begin
                    state_nxt_s = ST_REF_WAIT;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_REF_WAIT: begin
                if (bm_refresh_gnt == {NBANK{1'b1}}) begin
                    state_nxt_s = ST_REF_ISSUE;
                end else begin
                    state_nxt_s = ST_REF_WAIT;
                end
            end
            ST_REF_ISSUE: state_nxt_s = ST_REF_HOLD;
            ST_REF_HOLD: begin
                if (!refresh_req) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_REF_HOLD;
                end
            end
            default: state_nxt_s = ST_ARB;
        endcase
    end

    assign refresh_done = (state_r == ST_REF_ISSUE) && init_done_r;

    // FSM state and round-robin pointer (advances only past a granted bank).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r  <= ST_ARB;
            rr_ptr_r <= {BANK_IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                rr_ptr_r <= grant_idx_s + BANK_IDX_W'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // PHY command register: granted command, REF, or an all-zero idle slot.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phy_cmd_valid    <= 1'b0;
            phy_cmd_a        <= 17'd0;
            phy_cmd_ba       <= 3'd0;
            phy_cmd_cas      <= 1'b0;
            phy_cmd_ras      <= 1'b0;
            phy_cmd_we       <= 1'b0;
            phy_cmd_is_read  <= 1'b0;
            phy_cmd_is_write <= 1'b0;
        end else if (grant_s) begin
            phy_cmd_valid    <= 1'b1;
            phy_cmd_a        <= bm_cmd_a[int'(grant_idx_s)*ADDR_W +: ADDR_W];
            phy_cmd_ba       <= bm_cmd_ba[int'(grant_idx_s)*BA_W +: BA_W];
            phy_cmd_cas      <= bm_cmd_cas[grant_idx_s];
            phy_cmd_ras      <= bm_cmd_ras[grant_idx_s];
            phy_cmd_we       <= bm_cmd_we[grant_idx_s];
            phy_cmd_is_read  <= bm_cmd_is_read[grant_idx_s];
            phy_cmd_is_write <= bm_cmd_is_write[grant_idx_s];
        end else if (refresh_done) begin
            phy_cmd_valid    <= 1'b1;
            phy_cmd_a        <= 17'd0;
            phy_cmd_ba       <= 3'd0;
            phy_cmd_cas      <= 1'b1;
            phy_cmd_ras      <= 1'b1;
            phy_cmd_we       <= 1'b0;
            phy_cmd_is_read  <= 1'b0;
            phy_cmd_is_write <= 1'b0;
        end else begin
            phy_cmd_valid    <= 1'b0;
            phy_cmd_a        <= 17'd0;
            phy_cmd_ba       <= 3'd0;
            phy_cmd_cas      <= 1'b0;
            phy_cmd_ras      <= 1'b0;
            phy_cmd_we       <= 1'b0;
            phy_cmd_is_read  <= 1'b0;
            phy_cmd_is_write <= 1'b0;
        end
    end

endmodule
